writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I core.
- Captures results from the memory stage and extracts and extends load data by load type.
- Drives the register-file write port (reg_file_wr_en / reg_file_wr_addr / reg_file_wr_data) consumed by decode_stage, the far end of that interface.
- Keeps a retired-instruction counter for debug/perf.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mem_valid  input  1  memory-stage slot holds a real instruction
- mem_rd  input  5  destination register
- mem_alu_result  input  32  ALU result; bits [1:0] are the load byte offset
- mem_load_data  input  32  raw aligned word read from data memory
- mem_load_type  input  3  LB=000, LH=001, LW=010, LBU=011, LHU=100; other codes are treated as LW
- mem_wb_load  input  1  writeback source is load data (else ALU result)
- mem_wb_reg_file  input  1  instruction writes rd
- wb_stall  input  1  hold the MEM/WB register
- wb_flush  input  1  kill the incoming slot
- reg_file_wr_en  output  1  register-file write enable
- reg_file_wr_addr  output  5  register-file write address
- reg_file_wr_data  output  32  register-file write data
- wb_valid  output  1  registered slot valid
- retire_count  output  CNT_W  retired-instruction count

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). Reset has priority over all other inputs, including mid-stall.
- Reset state: wb_valid=0; all stage-register fields=0; retire_count=0.
  - Outputs after reset: reg_file_wr_en=0, reg_file_wr_addr=0, reg_file_wr_data=0.
- Stage register, updated at posedge:
  - rst → clear everything.
  - else if wb_flush → wb_valid<=0; other fields don't-care (held). Flush wins over stall.
  - else if wb_stall → hold all fields.
  - else → capture all mem_* inputs; wb_valid<=mem_valid.
- Latency: one cycle from memory-stage inputs to the register-file write outputs.
- Write port, combinational from registered fields:
  - reg_file_wr_en = wb_valid & wb_reg_file & (wb_rd != 0). Writes to x0 are always suppressed.
  - reg_file_wr_addr = wb_rd when reg_file_wr_en=1, else 0.
  - reg_file_wr_data = selected data when reg_file_wr_en=1, else 0.
  - Selected data = extracted load data if wb_load, else wb_alu_result.
- Load extraction, with off = wb_alu_result[1:0]:
  - LB/LBU: byte = word[8*off+7 : 8*off]; LB sign-extends from bit 7, LBU zero-extends.
  - LH/LHU: half = off[1] ? word[31:16] : word[15:0]; off[0] is ignored (no misaligned trap); LH sign-extends from bit 15, LHU zero-extends.
  - LW and unused codes: full word; offset ignored.
- Stall behaviour: while wb_stall=1 and not flushed, the same write is presented every cycle. The register-file write is idempotent, so this is legal.
- Retire counter: increments by 1 on each posedge where wb_valid=1 and the stage advances (wb_stall=0 or wb_flush=1).
  - Counts valid instructions including rd=x0 and stores; a stalled slot is counted once.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous flush and a valid incoming slot: the incoming slot is dropped. The current slot (if valid) still retires and writes that cycle.

Test Plan:
- Reset, then ALU result: rst high 2 cycles → all outputs 0. Then mem_valid=1, rd=5, alu=0x0000_1234, wb_reg_file=1, wb_load=0 → next cycle wr_en=1, addr=5, data=0x0000_1234; retire_count=1 one cycle later.
- Load types with word=0x8765_F0A1:
  - LB off=0 → 0xFFFF_FFA1; LBU off=1 → 0x0000_00F0.
  - LH off=2 → 0xFFFF_8765; LHU off=2 → 0x0000_8765.
  - LW → 0x8765_F0A1; type=111 → 0x8765_F0A1.
- x0 suppression: rd=0, wb_reg_file=1, alu=0xDEAD_BEEF → wr_en=0, addr=0, data=0; retire_count still increments.
- Stall/flush:
  - Load rd=9 data=0xCAFE_BABE, then wb_stall=1 for 3 cycles → write held constant; retire_count increments only once.
  - wb_flush=1 together with wb_stall=1 → wb_valid=0 next cycle.
- Wrap and reset mid-operation:
  - CNT_W=4, 17 valid instructions → retire_count=1.
  - rst asserted while wb_stall=1 and wb_valid=1 → next cycle all outputs 0.
- Back-to-back issue: rd=1..4 on consecutive cycles, no stall → four consecutive writes with matching addr/data, one per cycle.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback logic for the RV32I core.
// Extracts and extends load data, drives the register-file write port and counts retired instructions.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [2:0]       mem_load_type,
  input  logic             mem_wb_load,
  input  logic             mem_wb_reg_file,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             reg_file_wr_en,
  output logic [4:0]       reg_file_wr_addr,
  output logic [XLEN-1:0]  reg_file_wr_data,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic             valid_q,  valid_d;
  logic [4:0]       rd_q,     rd_d;
  logic [XLEN-1:0]  alu_q,    alu_d;
  logic [XLEN-1:0]  word_q,   word_d;
  logic [2:0]       lt_q,     lt_d;
  logic             load_q,   load_d;
  logic             regf_q,   regf_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic advance;
  logic retire_inc;

  // A stalled slot retires once, on the cycle it finally leaves (or is flushed out).
  assign advance    = ~wb_stall | wb_flush;
  assign retire_inc = valid_q & advance;

  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    alu_d    = alu_q;
    word_d   = word_q;
    lt_d     = lt_q;
    load_d   = load_q;
    regf_d   = regf_q;
    retire_d = retire_q + {{(CNT_W-1){1'b0}}, retire_inc};
    if (wb_flush) begin
      valid_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d = mem_valid;
      rd_d    = mem_rd;
      alu_d   = mem_alu_result;
      word_d  = mem_load_data;
      lt_d    = mem_load_type;
      load_d  = mem_wb_load;
      regf_d  = mem_wb_reg_file;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rd_q     <= '0;
      alu_q    <= '0;
      word_q   <= '0;
      lt_q     <= '0;
      load_q   <= 1'b0;
      regf_q   <= 1'b0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      alu_q    <= alu_d;
      word_q   <= word_d;
      lt_q     <= lt_d;
      load_q   <= load_d;
      regf_q   <= regf_d;
      retire_q <= retire_d;
    end
  end

  logic [7:0]      lane [4];
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] sel_data;
  logic            wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_q[8*gi +: 8];
    end
  endgenerate

  // Halfword selection ignores off[0]; misaligned halves are not trapped here.
  assign off      = alu_q[1:0];
  assign byte_sel = lane[off];
  assign half_sel = off[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    load_ext = word_q;
    case (lt_q)
      LT_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_ext = {24'h0, byte_sel};
      LT_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_ext = {16'h0, half_sel};
      default: load_ext = word_q;
    endcase
  end

  assign sel_data = load_q ? load_ext : alu_q;
  assign wr_en    = valid_q & regf_q & (rd_q != 5'd0);

  assign reg_file_wr_en   = wr_en;
  assign reg_file_wr_addr = wr_en ? rd_q : 5'd0;
  assign reg_file_wr_data = wr_en ? sel_data : '0;
  assign wb_valid         = valid_q;
  assign retire_count     = retire_q;

endmodule
